huff_enc_sched: RTL and testbench
=================================

Name: huff_enc_sched

Overview:
- Scheduler/controller for the Huffman serial output path.
- Accepts a stream of symbols 0-9 over a valid/ready handshake and buffers them in a small FIFO.
- For each symbol it looks up the 13-bit code in a writable 10-entry table and serializes it MSB-first on Out/Outt with downstream backpressure.
- Counts emitted bits and pulses Fin at end of stream.

Parameters:
- DEPTH, 4, symbol FIFO depth in entries (power of 2, 2..16).
- CNT_W, 16, width of the emitted-bit counter Bit_cnt.

Ports:
- Clk_in  in  1  single clock; all logic on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Tbl_we  in  1  code-table write strobe.
- Tbl_addr  in  4  table entry index; 0-9 valid, 10-15 ignored.
- Tbl_data  in  13  code word: [12:9] = length L, [8:0] = code bits, with bit L-1 sent first.
- Sym_valid  in  1  symbol present.
- Sym  in  4  symbol index.
- Sym_last  in  1  marks the final symbol of a stream; qualified by Sym_valid.
- Sym_ready  out  1  FIFO not full.
- Out  out  1  serial code bit.
- Outt  out  1  Out is valid.
- Out_ready  in  1  downstream accepts Out this cycle.
- Busy  out  1  FIFO non-empty or a symbol is in flight.
- Fin  out  1  one-cycle pulse after the last bit of a Sym_last symbol.
- Err  out  1  sticky: an invalid symbol or code was seen.
- Bit_cnt  out  CNT_W  bits emitted in the current/last stream.

Behaviour:
- Reset (async, Rst=1):
  - State=IDLE, FIFO empty, table entries all 0.
  - Out=0, Outt=0, Fin=0, Err=0, Bit_cnt=0, Busy=0, Sym_ready=1 (after reset is released).
- Table writes:
  - Accepted any cycle, including while busy. Writes to addr >= 10 are dropped.
  - A write takes effect for every symbol that enters LOAD after the write edge. The symbol currently in flight is unaffected, because its code is latched in LOAD.
- FIFO:
  - Push when Sym_valid & Sym_ready. Each entry stores {Sym_last, Sym}.
  - Sym_ready = !full, computed from registered state. When full, no push occurs even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: occupancy is unchanged.
- State machine:
  - IDLE: if FIFO non-empty -> LOAD.
  - LOAD (1 cycle):
    - Pop the head entry and latch code = table[Sym] and L = code[12:9].
    - If Sym > 9, or L == 0, or L > 9: set Err, emit no bits, and go to END if last, else IDLE.
    - Otherwise set idx = L-1 and go to BITS (or HDR when the option is enabled).
  - BITS:
    - Drive Out = code[idx], Outt = 1.
    - On Out_ready=1: Bit_cnt += 1 (saturating at all-ones). If idx == 0, go to END if last, else IDLE; otherwise idx -= 1.
    - On Out_ready=0: Out, Outt, idx and Bit_cnt hold.
  - END: Fin=1 for exactly 1 cycle, Outt=0 -> IDLE.
- Outt is 0 in every state except BITS/HDR.
- Latency: a symbol pushed into an empty FIFO in cycle n is in LOAD at n+1. Its first bit is valid at n+2.
- Back-to-back symbols: one idle LOAD cycle (Outt=0) separates consecutive codes.
- Bit_cnt clears to 0 on the LOAD of the first symbol after a Fin (or after reset), and otherwise holds its value after Fin.
- Err is cleared only by Rst.
- Busy = FIFO non-empty | (state != IDLE).
- Rst asserted mid-symbol aborts immediately: FIFO is flushed, table is cleared, and no Fin is issued.

Optional Feature:
- Macro HUFF_LEN_HDR_EN.
- Defined: after LOAD, state HDR sends the 4-bit length L MSB-first (4 bits, same Out_ready handshake, counted in Bit_cnt) and then enters BITS. Invalid symbols send no header.
- Undefined: HDR state and its logic are absent, and LOAD goes directly to BITS.

Test Plan:
- Table[3]=13'h0A05 (L=5, bits 00101); push Sym=3 with last=1, Out_ready=1 -> Out sequence 0,0,1,0,1 on 5 consecutive Outt cycles, Fin pulse 1 cycle later, Bit_cnt=5. With HUFF_LEN_HDR_EN the sequence is 0,1,0,1 then 0,0,1,0,1 and Bit_cnt=9.
- Backpressure: same stimulus with Out_ready low for 3 cycles during the 2nd bit -> Out=0 and Outt=1 are held for 3 cycles, the total bit sequence is unchanged, and Bit_cnt=5.
- FIFO full: DEPTH=4, Out_ready=0, push 6 symbols -> Sym_ready drops after 5 accepted (1 in flight + 4 buffered); the 6th is held off until a pop, and all symbols are encoded in order.
- Invalid: push Sym=12, then Sym=1 (table[1]=13'h0201, L=1, bit 1) with last -> Err=1, no bits for 12, a single Out=1 bit, Fin pulses, Bit_cnt=1.
- Table rewrite while busy: write table[3] during BITS of symbol 3; the next queued symbol 3 uses the new code and the current one finishes with the old code.
- Reset mid-stream: assert Rst during BITS -> Outt=0, Busy=0, Fin=0, Bit_cnt=0 and Err=0 immediately, asynchronously.

Source files
------------

// File: rtl/huff_enc_sched.sv
// Huffman serial-output scheduler: symbol FIFO, writable 10-entry code table, MSB-first serializer.
// Optional macro HUFF_LEN_HDR_EN prefixes each valid code with its 4-bit length.
module huff_enc_sched #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             Clk_in,
  input  logic             Rst,
  input  logic             Tbl_we,
  input  logic [3:0]       Tbl_addr,
  input  logic [12:0]      Tbl_data,
  input  logic             Sym_valid,
  input  logic [3:0]       Sym,
  input  logic             Sym_last,
  output logic             Sym_ready,
  output logic             Out,
  output logic             Outt,
  input  logic             Out_ready,
  output logic             Busy,
  output logic             Fin,
  output logic             Err,
  output logic [CNT_W-1:0] Bit_cnt,
  output logic [2:0]       Dbg_state
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_BITS = 3'd2,
    S_END  = 3'd3
`ifdef HUFF_LEN_HDR_EN
    , S_HDR = 3'd4
`endif
  } state_t;

  state_t            r_state;
  logic [4:0]        r_mem [DEPTH];
  logic [AW-1:0]     r_wr, r_rd;
  logic [AW:0]       r_count;
  logic [12:0]       r_tbl [10];
  logic [12:0]       r_code;
  logic              r_last;
  logic [3:0]        r_idx;
  logic              r_out, r_outt, r_fin, r_err, r_new;
  logic [CNT_W-1:0]  r_cnt;
`ifdef HUFF_LEN_HDR_EN
  logic [1:0]        r_hidx;
`endif

  logic              w_push, w_pop, w_bad, w_more;
  logic [AW:0]       w_cnt_nxt;
  logic [4:0]        w_head;
  logic [12:0]       w_code;
  logic [3:0]        w_len, w_rlen;

  // Handshake: a symbol transfers on a rising edge where Sym_valid & Sym_ready; Sym_ready depends only on registered occupancy.
  assign Sym_ready = (r_count != C_FULL);
  assign w_push    = Sym_valid & Sym_ready;
  assign w_pop     = (r_state == S_LOAD);
  assign w_cnt_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_more    = (w_cnt_nxt != '0);
  assign w_head    = r_mem[r_rd];
  assign w_len     = w_code[12:9];
  assign w_rlen    = r_code[12:9];
  assign w_bad     = (w_head[3:0] > 4'd9) | (w_len == 4'd0) | (w_len > 4'd9);

  always_comb begin
    w_code = '0;
    for (int i = 0; i < 10; i++)
      if (w_head[3:0] == 4'(i)) w_code = r_tbl[i];
  end

  always_ff @(posedge Clk_in) begin
    if (w_push) r_mem[r_wr] <= {Sym_last, Sym};
  end

  always_ff @(posedge Clk_in or posedge Rst) begin
    if (Rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= w_cnt_nxt;
    end
  end

  always_ff @(posedge Clk_in or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < 10; i++) r_tbl[i] <= '0;
    end else if (Tbl_we && Tbl_addr <= 4'd9) begin
      r_tbl[Tbl_addr] <= Tbl_data;
    end
  end

  // The code is latched in LOAD, so table writes never disturb the symbol in flight.
  always_ff @(posedge Clk_in or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_last  <= 1'b0;
      r_idx   <= '0;
      r_out   <= 1'b0;
      r_outt  <= 1'b0;
      r_fin   <= 1'b0;
      r_err   <= 1'b0;
      r_new   <= 1'b1;
      r_cnt   <= '0;
`ifdef HUFF_LEN_HDR_EN
      r_hidx  <= '0;
`endif
    end else begin
      r_fin <= 1'b0;
      case (r_state)
        S_IDLE: if (w_more) r_state <= S_LOAD;
        S_LOAD: begin
          r_code <= w_code;
          r_last <= w_head[4];
          if (r_new) begin
            r_cnt <= '0;
            r_new <= 1'b0;
          end
          if (w_bad) begin
            r_err <= 1'b1;
            if (w_head[4]) begin
              r_state <= S_END;
              r_fin   <= 1'b1;
            end else begin
              r_state <= w_more ? S_LOAD : S_IDLE;
            end
          end else begin
            r_idx  <= w_len - 4'd1;
            r_outt <= 1'b1;
`ifdef HUFF_LEN_HDR_EN
            r_state <= S_HDR;
            r_hidx  <= 2'd3;
            r_out   <= w_len[3];
`else
            r_state <= S_BITS;
            r_out   <= w_code[w_len - 4'd1];
`endif
          end
        end
`ifdef HUFF_LEN_HDR_EN
        S_HDR: if (Out_ready) begin
          if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
          if (r_hidx == 2'd0) begin
            r_state <= S_BITS;
            r_out   <= r_code[r_idx];
          end else begin
            r_hidx <= r_hidx - 2'd1;
            r_out  <= w_rlen[r_hidx - 2'd1];
          end
        end
`endif
        S_BITS: if (Out_ready) begin
          if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
          if (r_idx == 4'd0) begin
            r_outt <= 1'b0;
            r_out  <= 1'b0;
            if (r_last) begin
              r_state <= S_END;
              r_fin   <= 1'b1;
            end else begin
              r_state <= w_more ? S_LOAD : S_IDLE;
            end
          end else begin
            r_idx <= r_idx - 4'd1;
            r_out <= r_code[r_idx - 4'd1];
          end
        end
        S_END: begin
          r_state <= S_IDLE;
          r_new   <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Out       = r_out;
  assign Outt      = r_outt;
  assign Fin       = r_fin;
  assign Err       = r_err;
  assign Bit_cnt   = r_cnt;
  assign Busy      = (r_count != '0) | (r_state != S_IDLE);
  assign Dbg_state = r_state;
endmodule

// File: tb/tb_huff_enc_sched.sv
// Directed bench for huff_enc_sched: expected serial bits queued at stimulus time, checked by a monitor.
module tb_huff_enc_sched;
`ifdef HUFF_LEN_HDR_EN
  localparam int HDR_BITS = 4;
`else
  localparam int HDR_BITS = 0;
`endif

  logic        Clk_in = 1'b0;
  logic        Rst = 1'b1;
  logic        Tbl_we = 1'b0;
  logic [3:0]  Tbl_addr = '0;
  logic [12:0] Tbl_data = '0;
  logic        Sym_valid = 1'b0;
  logic [3:0]  Sym = '0;
  logic        Sym_last = 1'b0;
  logic        Sym_ready, Out, Outt, Busy, Fin, Err;
  logic        Out_ready = 1'b1;
  logic [15:0] Bit_cnt;
  logic [2:0]  Dbg_state;

  logic [0:0]  exp_q[$];
  logic [12:0] tb_tbl [10];
  int          n_checks = 0;
  int          n_errs = 0;
  int          fin_cnt = 0;
  logic        fin_prev = 1'b0;
  int          exp_bits = 0;

  huff_enc_sched #(.DEPTH(4), .CNT_W(16)) dut (
    .Clk_in(Clk_in), .Rst(Rst), .Tbl_we(Tbl_we), .Tbl_addr(Tbl_addr), .Tbl_data(Tbl_data),
    .Sym_valid(Sym_valid), .Sym(Sym), .Sym_last(Sym_last), .Sym_ready(Sym_ready),
    .Out(Out), .Outt(Outt), .Out_ready(Out_ready), .Busy(Busy), .Fin(Fin), .Err(Err),
    .Bit_cnt(Bit_cnt), .Dbg_state(Dbg_state)
  );

  // Clock / reset
  always #5 Clk_in = ~Clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tbl_write(input logic [3:0] a, input logic [12:0] d);
    Tbl_we = 1'b1; Tbl_addr = a; Tbl_data = d;
    @(posedge Clk_in); #1;
    Tbl_we = 1'b0;
    if (a <= 4'd9) tb_tbl[a] = d;
  endtask

  task automatic push_sym(input logic [3:0] s, input logic last);
    int t = 0;
    Sym_valid = 1'b1; Sym = s; Sym_last = last;
    while (!Sym_ready && t < 300) begin
      @(posedge Clk_in); #1; t++;
    end
    if (t >= 300) check("push_timeout", 1, 0);
    @(posedge Clk_in); #1;
    Sym_valid = 1'b0; Sym_last = 1'b0;
  endtask

  task automatic exp_code(input logic [12:0] c);
    logic [3:0] l;
    l = c[12:9];
    if (l != 4'd0 && l <= 4'd9) begin
`ifdef HUFF_LEN_HDR_EN
      for (int i = 3; i >= 0; i--) exp_q.push_back(l[i]);
`endif
      for (int i = int'(l) - 1; i >= 0; i--) exp_q.push_back(c[i]);
      exp_bits += int'(l) + HDR_BITS;
    end
  endtask

  task automatic exp_sym(input logic [3:0] s);
    if (s <= 4'd9) exp_code(tb_tbl[s]);
  endtask

  task automatic wait_fin(input int budget);
    int f0 = fin_cnt;
    int t = 0;
    while (fin_cnt == f0 && t < budget) begin
      @(posedge Clk_in); #1; t++;
    end
    check("fin_seen", fin_cnt != f0, 1);
  endtask

  task automatic wait_outt(input int budget);
    int t = 0;
    while (!Outt && t < budget) begin
      @(posedge Clk_in); #1; t++;
    end
    check("outt_seen", Outt, 1);
  endtask

  // Scoreboard monitor
  always @(negedge Clk_in) begin
    if (!Rst) begin
      if (Fin) begin
        fin_cnt++;
        if (fin_prev) check("fin_width", 2, 1);
      end
      fin_prev = Fin;
      if (Outt) begin
        if (exp_q.size() == 0) check("unexpected_bit", {31'd0, Out}, 32'hdead);
        else if (Out_ready) check("out_bit", Out, exp_q.pop_front());
        else check("out_hold", Out, exp_q[0]);
      end
    end
  end

  initial begin
    int f0;
    for (int i = 0; i < 10; i++) tb_tbl[i] = '0;
    repeat (3) @(posedge Clk_in);
    #1 Rst = 1'b0;
    @(posedge Clk_in); #1;
    check("rst_outt", Outt, 0);
    check("rst_out", Out, 0);
    check("rst_fin", Fin, 0);
    check("rst_err", Err, 0);
    check("rst_bitcnt", Bit_cnt, 0);
    check("rst_busy", Busy, 0);
    check("rst_ready", Sym_ready, 1);

    tbl_write(4'd3, 13'h0A05);
    tbl_write(4'd1, 13'h0201);
    tbl_write(4'd12, 13'h0FFF);

    // Basic code, latency and Fin timing
    exp_bits = 0;
    exp_sym(4'd3);
    push_sym(4'd3, 1'b1);
    check("t1_load_outt", Outt, 0);
    check("t1_load_busy", Busy, 1);
    @(posedge Clk_in); #1;
    check("t1_first_bit_valid", Outt, 1);
    repeat (5 + HDR_BITS) @(posedge Clk_in);
    #1;
    check("t1_fin", Fin, 1);
    check("t1_outt_end", Outt, 0);
    check("t1_bitcnt", Bit_cnt, 5 + HDR_BITS);
    check("t1_err", Err, 0);
    repeat (2) @(posedge Clk_in);
    #1 check("t1_idle_busy", Busy, 0);

    // Backpressure on the second bit
    exp_bits = 0;
    exp_sym(4'd3);
    push_sym(4'd3, 1'b1);
    repeat (2 + HDR_BITS) @(posedge Clk_in);
    #1 Out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk_in);
      check("t2_hold_outt", Outt, 1);
      check("t2_hold_out", Out, 0);
      @(posedge Clk_in); #1;
    end
    Out_ready = 1'b1;
    wait_fin(50);
    check("t2_bitcnt", Bit_cnt, exp_bits);

    // Invalid symbol then a 1-bit code
    exp_bits = 0;
    exp_sym(4'd12);
    exp_sym(4'd1);
    push_sym(4'd12, 1'b0);
    push_sym(4'd1, 1'b1);
    wait_fin(50);
    check("t3_err", Err, 1);
    check("t3_bitcnt", Bit_cnt, 1 + HDR_BITS);

    // FIFO full with downstream stalled
    exp_bits = 0;
    Out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_sym((i % 2 == 0) ? 4'd3 : 4'd1);
      push_sym((i % 2 == 0) ? 4'd3 : 4'd1, 1'b0);
    end
    check("t4_full_ready", Sym_ready, 0);
    repeat (3) @(posedge Clk_in);
    #1 check("t4_still_full", Sym_ready, 0);
    check("t4_busy", Busy, 1);
    Out_ready = 1'b1;
    exp_sym(4'd1);
    push_sym(4'd1, 1'b1);
    wait_fin(300);
    check("t4_bitcnt", Bit_cnt, exp_bits);

    // Table rewrite while a symbol is being serialized
    exp_bits = 0;
    Out_ready = 1'b0;
    exp_sym(4'd3);
    push_sym(4'd3, 1'b0);
    push_sym(4'd3, 1'b1);
    wait_outt(20);
    tbl_write(4'd3, 13'h0606);
    exp_sym(4'd3);
    Out_ready = 1'b1;
    wait_fin(100);
    check("t5_bitcnt", Bit_cnt, 8 + 2 * HDR_BITS);

    // Asynchronous reset during serialization
    exp_sym(4'd3);
    push_sym(4'd3, 1'b1);
    wait_outt(20);
    @(posedge Clk_in); #2;
    Rst = 1'b1;
    #1;
    exp_q.delete();
    for (int i = 0; i < 10; i++) tb_tbl[i] = '0;
    check("t6_outt", Outt, 0);
    check("t6_busy", Busy, 0);
    check("t6_fin", Fin, 0);
    check("t6_bitcnt", Bit_cnt, 0);
    check("t6_err", Err, 0);
    @(posedge Clk_in); #1;
    Rst = 1'b0;
    f0 = fin_cnt;
    repeat (3) @(posedge Clk_in);
    #1 check("t6_no_fin", fin_cnt, f0);
    check("t6_ready", Sym_ready, 1);
    // Cleared table makes symbol 3 an invalid code
    exp_sym(4'd3);
    push_sym(4'd3, 1'b1);
    wait_fin(50);
    check("t6_tbl_cleared_err", Err, 1);
    check("t6_tbl_cleared_cnt", Bit_cnt, 0);

    repeat (3) @(posedge Clk_in);
    #1 check("exp_q_drained", exp_q.size(), 0);

    // Final report
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
